// File: rtl/scp_loader.sv
// scp_loader: streams host bytes into SCP memory via the edit port, holding the CPU in reset meanwhile.
// Optional feature macro LOADER_CHECKSUM_EN adds a trailing checksum byte and the CHECK state.
`default_nettype none

module scp_loader (
  input  logic       CLK,
  input  logic       AR,
  input  logic       LOAD_REQ,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VLD,
  output logic       BYTE_RDY,
  output logic [7:0] MEM_ADDR,
  output logic [7:0] MEM_DATA,
  output logic       MEM_EDIT,
  output logic       CPU_RST,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_LEN    = 4'd2,
    S_DATA   = 4'd3,
    S_SETUP  = 4'd4,
    S_STROBE = 4'd5,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK  = 4'd6,
`endif
    S_DONE   = 4'd7,
    S_FAIL   = 4'd8
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       take;
  logic [7:0] ptr;
  logic [8:0] cnt;
  logic       load_req_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  always_ff @(posedge CLK or posedge AR) begin
    if (AR) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      S_IDLE: begin
        if (LOAD_REQ) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (!LOAD_REQ) begin
          state_nxt = S_FAIL;
        end else if (BYTE_VLD) begin
          take      = 1'b1;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (!LOAD_REQ) begin
          state_nxt = S_FAIL;
        end else if (BYTE_VLD) begin
          take      = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (!LOAD_REQ) begin
          state_nxt = S_FAIL;
        end else if (BYTE_VLD) begin
          take      = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        state_nxt = LOAD_REQ ? S_STROBE : S_FAIL;
      end
      S_STROBE: begin
        if (!LOAD_REQ) begin
          state_nxt = S_FAIL;
        end else if (cnt == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (!LOAD_REQ) begin
          state_nxt = S_FAIL;
        end else if (BYTE_VLD) begin
          take      = 1'b1;
          state_nxt = (BYTE_IN == sum) ? S_DONE : S_FAIL;
        end
      end
`endif
      S_DONE: begin
        if (!LOAD_REQ) state_nxt = S_IDLE;
      end
      S_FAIL: begin
        // Restart only on a fresh request edge so a held request cannot retrigger.
        if (LOAD_REQ && !load_req_q) state_nxt = S_ADDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BYTE_RDY = 1'b0;
    case (state)
      S_ADDR, S_LEN, S_DATA: BYTE_RDY = LOAD_REQ;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:               BYTE_RDY = LOAD_REQ;
`endif
      default:               BYTE_RDY = 1'b0;
    endcase
  end

  // Status outputs are registered from the next state so they change on the entering edge.
  always_ff @(posedge CLK or posedge AR) begin
    if (AR) begin
      MEM_EDIT   <= 1'b0;
      CPU_RST    <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      MEM_ADDR   <= 8'h00;
      MEM_DATA   <= 8'h00;
      ptr        <= 8'h00;
      cnt        <= 9'd0;
      load_req_q <= 1'b0;
    end else begin
      load_req_q <= LOAD_REQ;
      MEM_EDIT   <= (state_nxt == S_STROBE);
      CPU_RST    <= (state_nxt != S_IDLE);
      DONE       <= (state_nxt == S_DONE);
      ERR        <= (state_nxt == S_FAIL);
      if (take && (state == S_ADDR)) begin
        ptr <= BYTE_IN;
      end
      if (take && (state == S_LEN)) begin
        cnt <= (BYTE_IN == 8'h00) ? 9'd256 : {1'b0, BYTE_IN};
      end
      if (take && (state == S_DATA)) begin
        MEM_ADDR <= ptr;
        MEM_DATA <= BYTE_IN;
      end
      if (state == S_STROBE) begin
        ptr <= ptr + 8'd1;
        cnt <= cnt - 9'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or posedge AR) begin
    if (AR) begin
      sum <= 8'h00;
    end else if ((state_nxt == S_ADDR) && (state != S_ADDR)) begin
      sum <= 8'h00;
    end else if (take && (state == S_DATA)) begin
      sum <= sum + BYTE_IN;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_scp_loader.sv
// tb_scp_loader: table-driven and randomized program loads checked against a stream-level memory model.
`default_nettype none

module tb_scp_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       CLK      = 1'b0;
  logic       AR       = 1'b1;
  logic       LOAD_REQ = 1'b0;
  logic       BYTE_VLD = 1'b0;
  logic [7:0] BYTE_IN  = 8'h00;
  logic       BYTE_RDY, MEM_EDIT, CPU_RST, DONE, ERR;
  logic [7:0] MEM_ADDR, MEM_DATA;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mem_obs [256];
  logic [7:0]  mem_ref [256];
  logic [15:0] edit_log[$];
  int          strobes = 0;
  logic [16:0] hist1 = '0;
  logic [16:0] hist2 = '0;
  logic [16:0] cur_s;

  typedef struct {
    logic [7:0] a;
    logic [7:0] n;
    int         kind;
    int         idx;
    bit         bad_sum;
    bit         hold;
    int         dmode;
    bit         exp_done;
    int         exp_strobes;
  } vec_t;

  scp_loader dut (
    .CLK      (CLK),
    .AR       (AR),
    .LOAD_REQ (LOAD_REQ),
    .BYTE_IN  (BYTE_IN),
    .BYTE_VLD (BYTE_VLD),
    .BYTE_RDY (BYTE_RDY),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DATA (MEM_DATA),
    .MEM_EDIT (MEM_EDIT),
    .CPU_RST  (CPU_RST),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Memory side: record every strobe and check address/data hold around each pulse.
  always @(negedge CLK) begin
    cur_s = {MEM_EDIT, MEM_ADDR, MEM_DATA};
    if (MEM_EDIT) begin
      mem_obs[MEM_ADDR] = MEM_DATA;
      edit_log.push_back({MEM_ADDR, MEM_DATA});
      strobes++;
    end
    if (hist1[16]) begin
      check("edit_width", {31'd0, MEM_EDIT}, 0);
      check("hold_before", {16'd0, hist2[15:0]}, {16'd0, hist1[15:0]});
      check("hold_after", {16'd0, cur_s[15:0]}, {16'd0, hist1[15:0]});
    end
    hist2 = hist1;
    hist1 = cur_s;
  end

  task automatic wait_rdy(output int w, output bit to);
    w  = 0;
    to = 1'b0;
    while (!BYTE_RDY) begin
      if (w >= 16) begin
        to = 1'b1;
        return;
      end
      tick();
      w++;
    end
  endtask

  // kind 0: full load; kind 1: drop request together with stream byte idx;
  // kind 2: drop request the cycle after data byte idx was accepted.
  task automatic run_load(input logic [7:0] a, input logic [7:0] n, input logic [7:0] d[$],
                          input int kind, input int idx, input bit bad_sum, input bit hold,
                          output bit got_done, output int got_strobes);
    logic [7:0]  stream[$];
    logic [15:0] exp_log[$];
    logic [7:0]  sum, cs, ad;
    int          len, waited, written, w, mism;
    bit          to, aborted, exp_done;
    len = (n == 8'h00) ? 256 : int'(n);
    sum = 8'h00;
    stream.push_back(a);
    stream.push_back(n);
    for (int i = 0; i < len; i++) begin
      stream.push_back(d[i]);
      sum = sum + d[i];
    end
    cs = bad_sum ? (sum + 8'd1) : sum;
    if (CSUM) stream.push_back(cs);

    strobes = 0;
    edit_log.delete();
    aborted = 1'b0;
    written = 0;
    LOAD_REQ = 1'b1;
    BYTE_VLD = 1'b0;
    tick();
    check("start_cpu_rst", {31'd0, CPU_RST}, 1);
    check("start_err", {31'd0, ERR}, 0);
    check("start_done", {31'd0, DONE}, 0);

    for (int j = 0; j < stream.size(); j++) begin
      BYTE_IN  = stream[j];
      BYTE_VLD = hold;
      wait_rdy(waited, to);
      if (to) begin
        check("rdy_timeout", {31'd0, BYTE_RDY}, 1);
        aborted = 1'b1;
        break;
      end
      if (hold && j >= 3) check("rdy_gap", waited, 2);
      if (kind == 1 && j == idx) begin
        BYTE_VLD = 1'b1;
        LOAD_REQ = 1'b0;
        tick();
        BYTE_VLD = 1'b0;
        check("abort_err", {31'd0, ERR}, 1);
        check("abort_edit", {31'd0, MEM_EDIT}, 0);
        aborted = 1'b1;
        break;
      end
      BYTE_VLD = 1'b1;
      tick();
      if (j >= 2 && j < len + 2) written++;
      if (kind == 2 && j == idx) begin
        LOAD_REQ = 1'b0;
        tick();
        check("abort_setup_edit", {31'd0, MEM_EDIT}, 0);
        check("abort_setup_err", {31'd0, ERR}, 1);
        written--;
        aborted = 1'b1;
        break;
      end
      if (!hold) begin
        BYTE_VLD = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    BYTE_VLD = 1'b0;

    if (!aborted) begin
      w = 0;
      while (!DONE && !ERR && w < 8) begin
        tick();
        w++;
      end
    end
    exp_done = !aborted && (!CSUM || !bad_sum);
    for (int i = 0; i < written; i++) begin
      ad = a + 8'(i);
      exp_log.push_back({ad, d[i]});
      mem_ref[ad] = d[i];
    end

    got_done = DONE;
    check("done", {31'd0, DONE}, {31'd0, exp_done});
    check("err", {31'd0, ERR}, {31'd0, !exp_done});
    check("cpu_rst_held", {31'd0, CPU_RST}, 1);
    LOAD_REQ = 1'b0;
    tick();
    check("cpu_rst_after_drop", {31'd0, CPU_RST}, {31'd0, !exp_done});
    check("err_after_drop", {31'd0, ERR}, {31'd0, !exp_done});
    tick();
    tick();
    got_strobes = strobes;
    check("strobe_count", strobes, written);
    check("edit_log_len", edit_log.size(), exp_log.size());
    mism = 0;
    for (int i = 0; i < exp_log.size() && i < edit_log.size(); i++)
      if (edit_log[i] !== exp_log[i]) mism++;
    check("edit_log", mism, 0);
    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem_obs[i] !== mem_ref[i]) mism++;
    check("mem_image", mism, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[10];
    logic [7:0] data[$];
    logic [7:0] ra, rn;
    bit         gd;
    int         gs, len, kind, idx, r, waited;
    bit         to;

    for (int i = 0; i < 256; i++) begin
      mem_obs[i] = 8'h00;
      mem_ref[i] = 8'h00;
    end
    //            a      n      kind idx bad hold dmode done strobes
    tbl[0] = '{8'h10, 8'h03, 0, 0, 1'b0, 1'b0, 2, 1'b1, 3};
    tbl[1] = '{8'hF0, 8'h20, 0, 0, 1'b0, 1'b0, 0, 1'b1, 32};
    tbl[2] = '{8'hFF, 8'h00, 0, 0, 1'b0, 1'b1, 1, 1'b1, 256};
    tbl[3] = '{8'h00, 8'h01, 0, 0, 1'b1, 1'b0, 3, !CSUM, 1};
    tbl[4] = '{8'h40, 8'h05, 1, 4, 1'b0, 1'b0, 0, 1'b0, 2};
    tbl[5] = '{8'h80, 8'h04, 1, 0, 1'b0, 1'b0, 0, 1'b0, 0};
    tbl[6] = '{8'h22, 8'h02, 1, 1, 1'b0, 1'b1, 0, 1'b0, 0};
    tbl[7] = '{8'h33, 8'h06, 0, 0, 1'b0, 1'b1, 0, 1'b1, 6};
    tbl[8] = '{8'h5A, 8'h03, 2, 3, 1'b0, 1'b0, 0, 1'b0, 1};
    tbl[9] = '{8'h60, 8'h08, 1, 6, 1'b0, 1'b1, 0, 1'b0, 4};

    tick();
    tick();
    check("rst_rdy", {31'd0, BYTE_RDY}, 0);
    check("rst_edit", {31'd0, MEM_EDIT}, 0);
    check("rst_cpu_rst", {31'd0, CPU_RST}, 0);
    check("rst_done", {31'd0, DONE}, 0);
    check("rst_err", {31'd0, ERR}, 0);
    check("rst_addr", {24'd0, MEM_ADDR}, 0);
    check("rst_data", {24'd0, MEM_DATA}, 0);
    AR = 1'b0;
    tick();

    // Asynchronous reset while a data byte sits between acceptance and strobe.
    strobes = 0;
    LOAD_REQ = 1'b1;
    tick();
    BYTE_VLD = 1'b1;
    BYTE_IN = 8'h50;
    wait_rdy(waited, to);
    tick();
    BYTE_IN = 8'h02;
    wait_rdy(waited, to);
    tick();
    BYTE_IN = 8'h77;
    wait_rdy(waited, to);
    tick();
    check("pre_ar_addr", {24'd0, MEM_ADDR}, 32'h50);
    #2 AR = 1'b1;
    #1;
    check("ar_rdy", {31'd0, BYTE_RDY}, 0);
    check("ar_edit", {31'd0, MEM_EDIT}, 0);
    check("ar_cpu_rst", {31'd0, CPU_RST}, 0);
    check("ar_done", {31'd0, DONE}, 0);
    check("ar_err", {31'd0, ERR}, 0);
    check("ar_addr", {24'd0, MEM_ADDR}, 0);
    check("ar_data", {24'd0, MEM_DATA}, 0);
    LOAD_REQ = 1'b0;
    BYTE_VLD = 1'b0;
    tick();
    check("ar_no_edit", {31'd0, MEM_EDIT}, 0);
    AR = 1'b0;
    tick();
    tick();
    check("ar_no_strobe", strobes, 0);

    for (int t = 0; t < 10; t++) begin
      len = (tbl[t].n == 8'h00) ? 256 : int'(tbl[t].n);
      data.delete();
      for (int i = 0; i < len; i++) begin
        case (tbl[t].dmode)
          0:       data.push_back(8'($urandom));
          1:       data.push_back(8'(i));
          2:       data.push_back((i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'hCC);
          default: data.push_back(8'h05);
        endcase
      end
      run_load(tbl[t].a, tbl[t].n, data, tbl[t].kind, tbl[t].idx,
               tbl[t].bad_sum, tbl[t].hold, gd, gs);
      check($sformatf("tbl%0d_done", t), {31'd0, gd}, {31'd0, tbl[t].exp_done});
      check($sformatf("tbl%0d_strobes", t), gs, tbl[t].exp_strobes);
    end

    for (int t = 0; t < 20; t++) begin
      ra  = 8'($urandom);
      rn  = 8'($urandom_range(1, 12));
      len = int'(rn);
      data.delete();
      for (int i = 0; i < len; i++) data.push_back(8'($urandom));
      r = $urandom_range(0, 5);
      kind = (r == 4) ? 1 : (r == 5) ? 2 : 0;
      idx = (kind == 1) ? $urandom_range(0, len + 1 + int'(CSUM)) : $urandom_range(2, len + 1);
      run_load(ra, rn, data, kind, idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gd, gs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
